// File: rtl/car_pass_generator.sv
// Two-beam (A, B) sensor waveform generator for entry/exit passes, with pass tallies.
// Optional car back-out support is built when BACKOUT_EN is defined.
module car_pass_generator #(
  parameter int unsigned STEP_CYCLES = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             start,
  input  logic             dir,
  input  logic             backout,
  output logic             A,
  output logic             B,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [CNT_W-1:0] n_entries,
  output logic [CNT_W-1:0] n_exits
);

  localparam int unsigned    PhW    = 16;
  localparam logic [PhW-1:0] PhLast = PhW'(STEP_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StP1,
    StP2,
    StP3
`ifdef BACKOUT_EN
    , StBack1
`endif
  } state_e;

  state_e         state_q, state_d;
  logic [PhW-1:0] phase_q, phase_d;
  logic           dir_q, dir_d;
  logic           done_d, inc_entry, inc_exit, phase_last;
  logic [1:0]     beams_d;
`ifdef BACKOUT_EN
  logic           aborted_d;
`else
  logic           unused_backout;
  assign unused_backout = backout;
  assign aborted        = 1'b0;
`endif

  assign phase_last = (phase_q == PhLast);

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q + PhW'(1);
    dir_d     = dir_q;
    done_d    = 1'b0;
    inc_entry = 1'b0;
    inc_exit  = 1'b0;
`ifdef BACKOUT_EN
    aborted_d = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        phase_d = '0;
        if (start) begin
          state_d = StP1;
          dir_d   = dir;
        end
      end
      StP1: begin
        if (phase_last) begin
          state_d = StP2;
          phase_d = '0;
        end
      end
      StP2: begin
`ifdef BACKOUT_EN
        // A reversing car overrides the phase timer.
        if (backout) begin
          state_d = StBack1;
          phase_d = '0;
        end else
`endif
        if (phase_last) begin
          state_d = StP3;
          phase_d = '0;
        end
      end
      StP3: begin
        if (phase_last) begin
          state_d   = StIdle;
          phase_d   = '0;
          done_d    = 1'b1;
          inc_entry = ~dir_q;
          inc_exit  = dir_q;
        end
      end
`ifdef BACKOUT_EN
      StBack1: begin
        if (phase_last) begin
          state_d   = StIdle;
          phase_d   = '0;
          aborted_d = 1'b1;
        end
      end
`endif
      default: begin
        state_d = StIdle;
        phase_d = '0;
      end
    endcase
  end

  // Beam pattern for the state being entered, so A/B are registered with the state.
  always_comb begin
    beams_d = 2'b00;
    unique case (state_d)
      StP1:    beams_d = dir_d ? 2'b01 : 2'b10;
      StP2:    beams_d = 2'b11;
      StP3:    beams_d = dir_d ? 2'b10 : 2'b01;
`ifdef BACKOUT_EN
      StBack1: beams_d = dir_d ? 2'b01 : 2'b10;
`endif
      default: beams_d = 2'b00;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= StIdle;
      phase_q   <= '0;
      dir_q     <= 1'b0;
      A         <= 1'b0;
      B         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      n_entries <= '0;
      n_exits   <= '0;
`ifdef BACKOUT_EN
      aborted   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      dir_q   <= dir_d;
      A       <= beams_d[1];
      B       <= beams_d[0];
      busy    <= (state_d != StIdle);
      done    <= done_d;
      if (inc_entry) n_entries <= n_entries + CNT_W'(1);
      if (inc_exit)  n_exits   <= n_exits + CNT_W'(1);
`ifdef BACKOUT_EN
      aborted <= aborted_d;
`endif
    end
  end

endmodule

// File: tb/tb_car_pass_generator.sv
// Scoreboard bench for car_pass_generator: expected per-cycle outputs are queued at stimulus
// time and compared on each falling edge.
module tb_car_pass_generator;

  localparam int unsigned S = 4;
`ifdef BACKOUT_EN
  localparam bit BackoutBuilt = 1'b1;
`else
  localparam bit BackoutBuilt = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RESET, start, dir, backout;
  logic       A, B, busy, done, aborted;
  logic [7:0] n_entries, n_exits;

  typedef struct packed {
    logic       a;
    logic       b;
    logic       busy;
    logic       done;
    logic       aborted;
    logic [7:0] ne;
    logic [7:0] nx;
  } obs_t;

  obs_t       sb_q[$];
  logic [7:0] exp_ne, exp_nx;
  int         checks   = 0;
  int         failures = 0;

  car_pass_generator #(.STEP_CYCLES(S), .CNT_W(8)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .start    (start),
    .dir      (dir),
    .backout  (backout),
    .A        (A),
    .B        (B),
    .busy     (busy),
    .done     (done),
    .aborted  (aborted),
    .n_entries(n_entries),
    .n_exits  (n_exits)
  );

  always #5 CLK = ~CLK;

  function automatic obs_t observe();
    return {A, B, busy, done, aborted, n_entries, n_exits};
  endfunction

  // Queue the expected cycle-by-cycle response of one pass, starting with the first P1 cycle.
  // back_at >= 0: backout is sampled after P2 has been shown back_at+1 cycles.
  function automatic void push_pass(input logic d, input int back_at);
    obs_t       o;
    logic [1:0] v1, v3;
    v1 = d ? 2'b01 : 2'b10;
    v3 = d ? 2'b10 : 2'b01;
    o = '0;
    o.busy = 1'b1;
    o.ne = exp_ne;
    o.nx = exp_nx;
    {o.a, o.b} = v1;
    repeat (S) sb_q.push_back(o);
    {o.a, o.b} = 2'b11;
    if (back_at >= 0 && BackoutBuilt) begin
      repeat (back_at + 1) sb_q.push_back(o);
      {o.a, o.b} = v1;
      repeat (S) sb_q.push_back(o);
      o = '0;
      o.aborted = 1'b1;
      o.ne = exp_ne;
      o.nx = exp_nx;
      sb_q.push_back(o);
    end else begin
      repeat (S) sb_q.push_back(o);
      {o.a, o.b} = v3;
      repeat (S) sb_q.push_back(o);
      if (d) exp_nx = exp_nx + 8'd1;
      else   exp_ne = exp_ne + 8'd1;
      o = '0;
      o.done = 1'b1;
      o.ne = exp_ne;
      o.nx = exp_nx;
      sb_q.push_back(o);
    end
  endfunction

  task automatic test_reset();
    RESET = 1'b1; start = 1'b0; dir = 1'b0; backout = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if (observe() !== '0) begin
      failures++;
      $display("FAIL reset_hold got=%b want=0", observe());
    end
    RESET = 1'b0;
    exp_ne = '0;
    exp_nx = '0;
    @(negedge CLK);
    checks++;
    if (observe() !== '0) begin
      failures++;
      $display("FAIL reset_idle got=%b want=0", observe());
    end
  endtask

  task automatic test_entry();
    obs_t got, want;
    start = 1'b1; dir = 1'b0;
    push_pass(1'b0, -1);
    for (int k = 0; sb_q.size() != 0; k++) begin
      @(negedge CLK);
      want = sb_q.pop_front();
      got = observe();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL entry k=%0d got=%b want=%b", k, got, want);
      end
      start = 1'b0;
    end
    checks++;
    if (n_entries !== 8'd1 || n_exits !== 8'd0) begin
      failures++;
      $display("FAIL entry_tally got=%0d/%0d want=1/0", n_entries, n_exits);
    end
  endtask

  task automatic test_exit();
    obs_t       got, want;
    logic [1:0] prev;
    prev = {A, B};
    start = 1'b1; dir = 1'b1;
    push_pass(1'b1, -1);
    for (int k = 0; sb_q.size() != 0; k++) begin
      @(negedge CLK);
      want = sb_q.pop_front();
      got = observe();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL exit k=%0d got=%b want=%b", k, got, want);
      end
      checks++;
      if ($countones(prev ^ {got.a, got.b}) > 1) begin
        failures++;
        $display("FAIL exit_single_bit k=%0d got=%b->%b want one bit change", k, prev,
                 {got.a, got.b});
      end
      prev = {got.a, got.b};
      start = 1'b0; dir = 1'b0;
    end
  endtask

  task automatic test_start_while_busy();
    obs_t got, want;
    start = 1'b1; dir = 1'b0;
    push_pass(1'b0, -1);
    for (int k = 0; sb_q.size() != 0; k++) begin
      @(negedge CLK);
      want = sb_q.pop_front();
      got = observe();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL busy_start k=%0d got=%b want=%b", k, got, want);
      end
      start = (k == 6);
    end
    @(negedge CLK);
    checks++;
    if ({A, B, busy, done} !== 4'b0000) begin
      failures++;
      $display("FAIL busy_start_after got=%b want=0000", {A, B, busy, done});
    end
  endtask

  task automatic test_backout();
    obs_t got, want;
    start = 1'b1; dir = 1'b0;
    push_pass(1'b0, 1);
    for (int k = 0; sb_q.size() != 0; k++) begin
      @(negedge CLK);
      want = sb_q.pop_front();
      got = observe();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL backout k=%0d got=%b want=%b", k, got, want);
      end
      start = 1'b0;
      backout = (k == 5);
    end
    backout = 1'b0;
  endtask

  task automatic test_back_to_back_wrap();
    obs_t got, want;
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    exp_ne = '0;
    exp_nx = '0;
    start = 1'b1; dir = 1'b0;
    for (int p = 0; p < 256; p++) push_pass(1'b0, -1);
    for (int k = 0; sb_q.size() != 0; k++) begin
      @(negedge CLK);
      want = sb_q.pop_front();
      got = observe();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL wrap k=%0d got=%b want=%b", k, got, want);
      end
      start = (sb_q.size() > 5);
    end
    checks++;
    if (n_entries !== 8'd0) begin
      failures++;
      $display("FAIL wrap_zero got=%0d want=0", n_entries);
    end
  endtask

  task automatic test_reset_mid_pass();
    obs_t got, want;
    start = 1'b1; dir = 1'b0;
    push_pass(1'b0, -1);
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      want = sb_q.pop_front();
      got = observe();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL mid_reset_pre k=%0d got=%b want=%b", k, got, want);
      end
      start = 1'b0;
    end
    sb_q.delete();
    exp_ne = '0;
    RESET = 1'b1;
    @(negedge CLK);
    checks++;
    if (observe() !== '0) begin
      failures++;
      $display("FAIL mid_reset got=%b want=0", observe());
    end
    RESET = 1'b0;
    for (int i = 0; i < 2 * S; i++) begin
      @(negedge CLK);
      checks++;
      if ({A, B, busy, done, aborted} !== 5'b00000) begin
        failures++;
        $display("FAIL mid_reset_after i=%0d got=%b want=00000", i, {A, B, busy, done, aborted});
      end
    end
  endtask

  initial begin
    test_reset();
    test_entry();
    test_exit();
    test_start_while_busy();
    test_backout();
    test_back_to_back_wrap();
    test_reset_mid_pass();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
